// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Instruction-fetch buffer between the PC stage and the ID stage.
//            It issues reads to a synchronous instruction ROM and captures
//            each returned word together with its PC. Up to DEPTH pc/inst
//            pairs are held in a FIFO and handed to ID in order under a
//            valid/stall handshake. A taken branch (flush_i) drops every
//            buffered and in-flight fetch.
// Ports    :
//   clk           in   single clock, rising-edge
//   rst           in   synchronous reset, active low
//   pc_i          in   fetch address from the PC stage
//   ce_i          in   PC stage chip enable (pc_i is a fetch request)
//   flush_i       in   taken branch from ID, kills buffered/in-flight work
//   stall_i       in   ID cannot accept this cycle
//   rom_data_i    in   ROM word, valid one cycle after an accepted request
//   rom_ce_o      out  ROM enable (also means "request accepted")
//   rom_addr_o    out  ROM address (pc_i)
//   fetch_stall_o out  PC stage must hold pc this cycle
//   id_valid_o    out  id_pc_o / id_inst_o hold a valid pair
//   id_pc_o       out  PC of the head instruction (0 when empty)
//   id_inst_o     out  head instruction word (0 when empty)
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              fetch_stall_o,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One extra bit so count + in-flight never wraps before the compare.
  localparam logic [CNT_W:0] C_DEPTH = (CNT_W + 1)'(DEPTH);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              req_v_q, req_v_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;

  logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
  logic [DATA_W-1:0] mem_inst_q [DEPTH];

  logic              accept;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    credit;

  // Credit includes the word still in flight from the ROM, so every
  // accepted request is guaranteed a slot when its data returns.
  assign credit        = {1'b0, count_q} + {{CNT_W{1'b0}}, req_v_q};
  assign fetch_stall_o = (credit >= C_DEPTH);

  assign rom_ce_o   = ce_i && !fetch_stall_o && !flush_i;
  assign rom_addr_o = pc_i;
  assign accept     = rom_ce_o;

  assign id_valid_o = (count_q != '0);
  assign id_pc_o    = id_valid_o ? mem_pc_q[rd_ptr_q]   : '0;
  assign id_inst_o  = id_valid_o ? mem_inst_q[rd_ptr_q] : '0;

  assign push = req_v_q && !flush_i;
  assign pop  = id_valid_o && !stall_i && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    req_v_d  = accept;
    req_pc_d = accept ? pc_i : req_pc_q;

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      req_v_d  = 1'b0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so the increment wraps.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      req_v_q  <= 1'b0;
      req_pc_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      req_v_q  <= req_v_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Storage needs no reset: entries are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_pc_q[wr_ptr_q]   <= req_pc_q;
      mem_inst_q[wr_ptr_q] <= rom_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Purpose  : Self-checking bench for if_fetch_queue. A short table of
//            hand-computed vectors covers reset and first-fetch latency; a
//            queue-based reference model then checks every output on every
//            cycle through stall, flush, wrap-around and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] C_XOR  = 32'hA5A5A5A5;
  localparam logic [31:0] C_IDLE = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        flush_i;
  logic        stall_i;
  logic [31:0] rom_data_i = 32'hDEADBEEF;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic        fetch_stall_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .ce_i         (ce_i),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .rom_data_i   (rom_data_i),
    .rom_ce_o     (rom_ce_o),
    .rom_addr_o   (rom_addr_o),
    .fetch_stall_o(fetch_stall_o),
    .id_valid_o   (id_valid_o),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o)
  );

  // Synchronous ROM: returns addr ^ A5A5A5A5 one cycle after an enabled
  // read, and a marker word otherwise so unrequested captures are visible.
  always @(posedge clk) begin
    rom_data_i <= rom_ce_o ? (rom_addr_o ^ C_XOR) : C_IDLE;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } pair_t;

  typedef struct {
    logic        rst;
    logic        ce;
    logic        flush;
    logic        stall;
    logic [31:0] pc;
    logic        chk;
    logic        valid;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        fstall;
  } vec_t;

  // Reference model state
  pair_t       m_q[$];
  bit          m_inflight = 1'b0;
  logic [31:0] m_inflight_pc = 32'h0;
  bit          m_known = 1'b0;

  int checks = 0;
  int errors = 0;

  logic        s_valid, s_fstall, s_romce;
  logic [31:0] s_pc, s_inst;
  bit          seen_fstall;
  bit          last_acc;
  logic [31:0] pc_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, compare with the model,
  // then advance the model across the rising edge.
  task automatic cyc(input logic r, input logic c, input logic f, input logic s,
                     input logic [31:0] pc);
    bit          e_stall, e_ce, e_valid;
    logic [31:0] e_pc, e_inst;
    pair_t       p;
    rst = r; ce_i = c; flush_i = f; stall_i = s; pc_i = pc;
    #4;
    s_valid  = id_valid_o;
    s_fstall = fetch_stall_o;
    s_romce  = rom_ce_o;
    s_pc     = id_pc_o;
    s_inst   = id_inst_o;
    if (s_fstall === 1'b1) seen_fstall = 1'b1;

    e_stall = (m_q.size() + int'(m_inflight)) >= DEPTH;
    e_ce    = c && !e_stall && !f;
    e_valid = (m_q.size() != 0);
    e_pc    = e_valid ? m_q[0].pc   : 32'h0;
    e_inst  = e_valid ? m_q[0].inst : 32'h0;
    if (m_known) begin
      chk("id_valid",    32'(s_valid),  32'(e_valid));
      chk("id_pc",       s_pc,          e_pc);
      chk("id_inst",     s_inst,        e_inst);
      chk("fetch_stall", 32'(s_fstall), 32'(e_stall));
      chk("rom_ce",      32'(s_romce),  32'(e_ce));
      chk("rom_addr",    rom_addr_o,    pc);
    end
    last_acc = e_ce;

    @(posedge clk);
    if (!r) begin
      m_q.delete();
      m_inflight    = 1'b0;
      m_inflight_pc = 32'h0;
      m_known       = 1'b1;
    end else if (f) begin
      m_q.delete();
      m_inflight = 1'b0;
    end else begin
      if (e_valid && !s) void'(m_q.pop_front());
      if (m_inflight) begin
        p.pc   = m_inflight_pc;
        p.inst = m_inflight_pc ^ C_XOR;
        m_q.push_back(p);
      end
      m_inflight = e_ce;
      if (e_ce) m_inflight_pc = pc;
    end
    #1;
  endtask

  // PC-stage behaviour: advance by 4 whenever the fetch was accepted.
  task automatic run(input logic r, input logic c, input logic f, input logic s, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(r, c, f, s, pc_next);
      if (last_acc) pc_next = pc_next + 32'd4;
    end
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h0,        1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h04, 1'b1, 1'b0, 32'h00, 32'h0,        1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 1'b1, 32'h00, 32'hA5A5A5A5, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b1, 1'b1, 32'h04, 32'hA5A5A5A1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h08, 32'hA5A5A5AD, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 1'b1, 32'h0C, 32'hA5A5A5A9, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 1'b1, 32'h10, 32'hA5A5A5B5, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 1'b0, 32'h00, 32'h0,        1'b0};

    rst = 1'b0; ce_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0; pc_i = 32'h0;
    seen_fstall = 1'b0;
    last_acc    = 1'b0;
    @(posedge clk);
    #1;

    // Reset, first-fetch latency and a short stream
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].rst, tbl[i].ce, tbl[i].flush, tbl[i].stall, tbl[i].pc);
      if (tbl[i].chk) begin
        chk("tbl_valid",  32'(s_valid),  32'(tbl[i].valid));
        chk("tbl_pc",     s_pc,          tbl[i].epc);
        chk("tbl_inst",   s_inst,        tbl[i].einst);
        chk("tbl_fstall", 32'(s_fstall), 32'(tbl[i].fstall));
      end
    end
    pc_next = 32'h14;

    // Stream into a held stall until full, then release
    seen_fstall = 1'b0;
    run(1'b1, 1'b1, 1'b0, 1'b1, 8);
    chk("t2_full_stall", 32'(s_fstall), 32'd1);
    chk("t2_stall_seen", 32'(seen_fstall), 32'd1);
    run(1'b1, 1'b1, 1'b0, 1'b0, 10);

    // Flush with three buffered and one in flight
    run(1'b1, 1'b0, 1'b1, 1'b0, 1);
    pc_next = 32'h200;
    run(1'b1, 1'b1, 1'b0, 1'b1, 4);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, pc_next);
    chk("t3_stall_pre_flush", 32'(s_fstall), 32'd1);
    chk("t3_romce_in_flush",  32'(s_romce),  32'd0);
    pc_next = 32'h100;
    run(1'b1, 1'b1, 1'b0, 1'b0, 1);
    chk("t3_empty_after_flush", 32'(s_valid), 32'd0);
    run(1'b1, 1'b1, 1'b0, 1'b0, 2);
    chk("t3_target_pc",   s_pc,   32'h100);
    chk("t3_target_inst", s_inst, 32'hA5A5A4A5);
    run(1'b1, 1'b1, 1'b0, 1'b0, 6);

    // Full FIFO with stall toggling: coincident push/pop across wrap
    run(1'b1, 1'b1, 1'b0, 1'b1, 6);
    for (int i = 0; i < 24; i++) begin
      run(1'b1, 1'b1, 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 1);
    end
    run(1'b1, 1'b0, 1'b0, 1'b0, 6);

    // Reset pulse with a request accepted in the same cycle
    run(1'b1, 1'b0, 1'b1, 1'b0, 1);
    run(1'b1, 1'b1, 1'b0, 1'b1, 3);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, pc_next);
    chk("t5_req_during_rst", 32'(s_romce), 32'd1);
    pc_next = pc_next + 32'd4;
    run(1'b1, 1'b0, 1'b0, 1'b0, 1);
    chk("t5_valid",  32'(s_valid),  32'd0);
    chk("t5_pc",     s_pc,          32'd0);
    chk("t5_inst",   s_inst,        32'd0);
    chk("t5_fstall", 32'(s_fstall), 32'd0);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1);
    chk("t5_rom_ignored", 32'(s_valid), 32'd0);
    run(1'b1, 1'b1, 1'b0, 1'b0, 6);

    // Flush against a valid head, then reset together with flush
    chk("t6_head_valid", 32'(s_valid), 32'd1);
    run(1'b1, 1'b1, 1'b1, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1);
    chk("t6_flush_empty", 32'(s_valid), 32'd0);
    run(1'b1, 1'b1, 1'b0, 1'b1, 4);
    run(1'b0, 1'b1, 1'b1, 1'b0, 1);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1);
    chk("t6_rst_valid",  32'(s_valid),  32'd0);
    chk("t6_rst_fstall", 32'(s_fstall), 32'd0);
    run(1'b1, 1'b1, 1'b0, 1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch buffer between the PC stage and the ID stage of the 5-stage MIPS32 pipeline.
- Takes the PC stage's pc/ce, issues a read to the synchronous instruction ROM, and captures the returned word with its PC.
- Stores up to DEPTH pc/inst pairs in a FIFO and presents them in order to ID under a valid/stall handshake.
- Provides back-pressure to the PC stage and discards all wrong-path fetches on a taken branch.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- ADDR_W, 32: PC / ROM address width.
- DATA_W, 32: instruction width.

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- rst  in  1  Synchronous, active-low reset.
- pc_i  in  ADDR_W  Fetch address from the PC stage.
- ce_i  in  1  PC stage chip-enable; 1 = pc_i is a valid fetch request.
- flush_i  in  1  Taken branch from ID (BRANCH); kills everything buffered and in flight.
- stall_i  in  1  ID cannot accept this cycle.
- rom_data_i  in  DATA_W  ROM read data, valid exactly 1 cycle after the accepted request.
- rom_ce_o  out  1  ROM enable; equals ce_i && !fetch_stall_o && !flush_i (combinational).
- rom_addr_o  out  ADDR_W  ROM address; equals pc_i (combinational).
- fetch_stall_o  out  1  PC stage must hold pc this cycle.
- id_valid_o  out  1  The id_pc_o / id_inst_o pair is valid.
- id_pc_o  out  ADDR_W  PC of the head instruction.
- id_inst_o  out  DATA_W  Head instruction word.

Behaviour:
- Reset (rst == 0 at a clk edge), applied to all state:
  - rd_ptr, wr_ptr, count cleared to 0.
  - req_v_q cleared to 0; req_pc_q cleared to 0.
  - Resulting outputs: id_valid_o = 0, id_pc_o = 0, id_inst_o = 0, fetch_stall_o = 0.
  - Reset has priority over flush_i, push and pop.
- Issue:
  - A request is accepted when rom_ce_o == 1.
  - On acceptance: req_v_q <= 1 and req_pc_q <= pc_i. Otherwise req_v_q <= 0.
- Capture:
  - When req_v_q == 1 and flush_i == 0, the pair {req_pc_q, rom_data_i} is written at wr_ptr.
  - wr_ptr then increments and wraps modulo DEPTH.
- Back-pressure:
  - fetch_stall_o = (count + req_v_q >= DEPTH).
  - This is a credit rule that includes the in-flight slot, so a push never overflows.
  - fetch_stall_o does not depend on stall_i (no combinational path from ID ready to PC).
- Output:
  - id_valid_o = (count != 0).
  - id_pc_o / id_inst_o are read combinationally from the entry at rd_ptr.
  - Both are forced to 0 when count == 0.
- Pop:
  - Occurs when id_valid_o && !stall_i && !flush_i.
  - rd_ptr then increments and wraps modulo DEPTH.
- Count update per cycle: count <= count + push - pop. Simultaneous push and pop leaves count unchanged and is legal at any occupancy, including full.
- Latency: a request accepted at cycle N is presented on id_*_o at cycle N+2 when the FIFO was empty. There is no bypass path.
- Throughput: 1 instruction/cycle sustained while stall_i == 0.
- Flush (flush_i == 1 at an edge):
  - rd_ptr, wr_ptr, count cleared to 0; req_v_q cleared to 0.
  - No push and no pop occur that cycle.
  - rom_ce_o is 0 during the flush cycle, so the branch target is fetched on the following cycle, when the PC stage presents it.
  - id_valid_o is 0 on the cycle after the flush.
- stall_i while empty: no effect.
- ce_i == 0: no issue; buffered entries continue to drain.
- Wrap-around: pointers are log2(DEPTH) bits and count is log2(DEPTH)+1 bits. Full is count == DEPTH and empty is count == 0, so there is no pointer-equality ambiguity.
- Reset mid-stream: the in-flight ROM word arriving on the cycle after reset release is ignored, because req_v_q == 0.

Test Plan:
1. Reset, then ce_i = 1 with pc_i = 0x0, 0x4, 0x8, ... and ROM data = addr ^ 0xA5A5A5A5, stall_i = 0 -> id_valid_o rises 2 cycles after the first accept. Required sequence: (0x0, 0xA5A5A5A5), (0x4, 0xA5A5A5A1), ..., one per cycle, fetch_stall_o held 0.
2. Stream as in 1, then stall_i = 1 held -> count reaches 4 and fetch_stall_o = 1 once count + req_v_q >= 4. No entry is lost or duplicated. Release stall_i -> PCs resume in strict order with no gap.
3. FIFO holding 3 entries with one in flight, assert flush_i for one cycle with pc_i = 0x100 on the next cycle -> id_valid_o = 0 the cycle after the flush, the stale in-flight word is dropped, and the first output is (0x100, ROM[0x100]) 2 cycles after its accept.
4. FIFO full with stall_i toggling 1/0 every cycle -> push and pop coincide, count stays at DEPTH or DEPTH-1, no overflow, order preserved across pointer wrap over more than 10 entries.
5. rst = 0 pulsed for one cycle while full and a request is in flight -> next cycle id_valid_o = 0, id_pc_o = 0, id_inst_o = 0, fetch_stall_o = 0. Returning ROM data is not captured.
6. Simultaneous flush_i = 1 and stall_i = 0 with a valid head -> no pop is counted and the FIFO empties. Simultaneous rst = 0 and flush_i = 1 -> reset state.
